bitslice_expander: RTL and testbench

- Sequential inverse of the bit counter (popcount) block. Accepts a count k and builds a BITSIZE-bit bitslice holding exactly min(k, BITSIZE) ones, packed in the LSBs (thermometer code).
- Generates the slice one bit per cycle. Each bit is also exposed as a serial stream.
- Used to produce popcount stimulus and round-trip checks for the garbled-circuit bit-counting path, and as a unary front end where a count must be re-expanded.

---
 rtl/bitslice_expander.sv | 117 +++++++++++
 tb/tb_bitslice_expander.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bitslice_expander.sv
// bitslice_expander: expands a count k into a thermometer-coded slice,
// one bit per cycle, with the bit stream also exposed serially.
module bitslice_expander #(
  parameter int BITSIZE     = 10,
  parameter int COUNTERSIZE = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [COUNTERSIZE-1:0] in_count,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [BITSIZE-1:0]     bitslice,
  output logic                   ser_valid,
  output logic                   ser_bit,
  output logic                   saturated
);

  localparam int KW = $clog2(BITSIZE + 1);
  localparam int IW = $clog2(BITSIZE);

  if (BITSIZE < 2) begin : g_bad_bitsize
    $error("bitslice_expander: BITSIZE must be >= 2");
  end

  if (COUNTERSIZE < KW) begin : g_bad_countersize
    $error("bitslice_expander: COUNTERSIZE too narrow for BITSIZE");
  end

  localparam logic [COUNTERSIZE-1:0] MAXC = COUNTERSIZE'(BITSIZE);
  localparam logic [KW-1:0]          MAXK = KW'(BITSIZE);
  localparam logic [IW-1:0]          LAST = IW'(BITSIZE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [KW-1:0]        kreg_q, kreg_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [BITSIZE-1:0]   slice_q, slice_d;
  logic                 sat_q, sat_d;

  logic                 over;
  logic                 fill_bit;

  assign over     = in_count > MAXC;
  assign fill_bit = KW'(idx_q) < kreg_q;

  // State and datapath registers; reset aborts any in-flight fill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      kreg_q  <= '0;
      idx_q   <= '0;
      slice_q <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      kreg_q  <= kreg_d;
      idx_q   <= idx_d;
      slice_q <= slice_d;
      sat_q   <= sat_d;
    end
  end

  // Next-state: accept in IDLE, write one bit per FILL cycle, hold in DONE.
  always_comb begin
    state_d = state_q;
    kreg_d  = kreg_q;
    idx_d   = idx_q;
    slice_d = slice_q;
    sat_d   = sat_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          kreg_d  = over ? MAXK : in_count[KW-1:0];
          sat_d   = over;
          slice_d = '0;
          idx_d   = '0;
          state_d = FILL;
        end
      end
      FILL: begin
        for (int i = 0; i < BITSIZE; i++) begin
          if (idx_q == IW'(i)) begin
            slice_d[i] = fill_bit;
          end
        end
        if (idx_q == LAST) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign ser_valid = state_q == FILL;
  assign ser_bit   = ser_valid & fill_bit;
  assign bitslice  = slice_q;
  assign saturated = sat_q;

endmodule

// File: tb/tb_bitslice_expander.sv
// tb_bitslice_expander: directed and random checks of bitslice_expander
// against a timeline model of accept / fill / done.
module tb_bitslice_expander;

  localparam int B  = 10;
  localparam int CW = 4;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [CW-1:0] in_count;
  logic          out_valid;
  logic          out_ready;
  logic [B-1:0]  bitslice;
  logic          ser_valid;
  logic          ser_bit;
  logic          saturated;

  int tests;
  int fails;
  int cyc;
  bit run;

  bitslice_expander #(.BITSIZE(B), .COUNTERSIZE(CW)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_count(in_count),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .bitslice(bitslice),
    .ser_valid(ser_valid),
    .ser_bit(ser_bit),
    .saturated(saturated)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d",
               nm, act, exp, cyc);
    end
  endtask

  function automatic logic [B-1:0] thermo(input int k);
    logic [B-1:0] r;
    r = '0;
    for (int i = 0; i < B; i++) if (i < k) r[i] = 1'b1;
    return r;
  endfunction

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Model: ph=0 idle, ph=1..B fill bit ph-1, ph=B+1 result held.
  int   ph;
  int   mk;
  logic msat;
  int   acc_cyc[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph   <= 0;
      mk   <= 0;
      msat <= 1'b0;
    end else if (ph == 0) begin
      if (in_valid) begin
        mk   <= (int'(in_count) > B) ? B : int'(in_count);
        msat <= int'(in_count) > B;
        ph   <= 1;
        acc_cyc.push_back(cyc);
      end
    end else if (ph <= B) begin
      ph <= ph + 1;
    end else if (out_ready) begin
      ph <= 0;
    end
  end

  always @(negedge clk) begin
    if (rst_n && run) begin
      chk("in_ready", in_ready, ph == 0);
      chk("out_valid", out_valid, ph == B + 1);
      chk("ser_valid", ser_valid, ph >= 1 && ph <= B);
      chk("ser_bit", ser_bit, (ph >= 1 && ph <= B) && (ph - 1 < mk));
      chk("saturated", saturated, msat);
      if (ph >= 1 && ph <= B)
        chk("partial", bitslice, thermo(imin(mk, ph - 1)));
      if (ph == B + 1) begin
        chk("bitslice", bitslice, thermo(mk));
        chk("popcount", $countones(bitslice), mk);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string nm);
    for (int w = 0; w < 40 && !in_ready; w++) tick();
    if (!in_ready) chk({nm, "_ready_timeout"}, 0, 1);
  endtask

  task automatic wait_done(input string nm);
    for (int w = 0; w < 40 && !out_valid; w++) tick();
    if (!out_valid) chk({nm, "_done_timeout"}, 0, 1);
  endtask

  task automatic start(input logic [CW-1:0] c, input string nm);
    wait_ready(nm);
    in_valid = 1'b1;
    in_count = c;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic xfer(input logic [CW-1:0] c, input logic [B-1:0] exp,
                      input logic es, input string nm);
    logic [B-1:0] sb;
    sb = '0;
    start(c, nm);
    for (int j = 0; j < B; j++) begin
      sb[j] = ser_bit;
      tick();
    end
    chk({nm, "_out_valid"}, out_valid, 1);
    chk({nm, "_slice"}, bitslice, exp);
    chk({nm, "_serial"}, sb, exp);
    chk({nm, "_sat"}, saturated, es);
    chk({nm, "_pop"}, $countones(bitslice), $countones(exp));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({nm, "_idle"}, in_ready, 1);
  endtask

  logic [B-1:0] held;
  logic [B-1:0] b2b_exp [3];
  logic [CW-1:0] b2b_cnt [3];
  int base;

  initial begin
    tests = 0; fails = 0; cyc = 0; run = 1'b0;
    rst_n = 1'b0; in_valid = 1'b0; in_count = '0; out_ready = 1'b0;
    repeat (3) tick();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_ser_valid", ser_valid, 0);
    chk("rst_ser_bit", ser_bit, 0);
    chk("rst_slice", bitslice, 0);
    chk("rst_sat", saturated, 0);
    rst_n = 1'b1;
    run = 1'b1;
    tick();

    xfer(4'd5, 10'b0000011111, 1'b0, "k5");
    xfer(4'd0, 10'b0000000000, 1'b0, "k0");
    xfer(4'd10, 10'b1111111111, 1'b0, "k10");
    xfer(4'd15, 10'b1111111111, 1'b1, "k15");
    xfer(4'd3, 10'b0000000111, 1'b0, "k3");

    start(4'd6, "bp");
    for (int j = 0; j < B + 2; j++) begin
      in_valid = j[0];
      in_count = 4'd7;
      if (!out_valid) tick();
    end
    wait_done("bp");
    held = bitslice;
    chk("bp_slice", held, 10'b0000111111);
    for (int j = 0; j < 6; j++) begin
      in_valid = ~in_valid;
      tick();
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_slice", bitslice, held);
      chk("bp_hold_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_release_ready", in_ready, 1);
    chk("bp_release_valid", out_valid, 0);

    start(4'd8, "rst");
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", in_ready, 1);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_ser_valid", ser_valid, 0);
    chk("mid_rst_ser_bit", ser_bit, 0);
    chk("mid_rst_slice", bitslice, 0);
    chk("mid_rst_sat", saturated, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_ready", in_ready, 1);
    xfer(4'd2, 10'b0000000011, 1'b0, "after_rst");

    b2b_cnt[0] = 4'd1; b2b_exp[0] = 10'b0000000001;
    b2b_cnt[1] = 4'd9; b2b_exp[1] = 10'b0111111111;
    b2b_cnt[2] = 4'd4; b2b_exp[2] = 10'b0000001111;
    base = acc_cyc.size();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_ready("b2b");
      in_valid = 1'b1;
      in_count = b2b_cnt[i];
      tick();
      wait_done("b2b");
      chk("b2b_slice", bitslice, b2b_exp[i]);
    end
    tick();
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("b2b_accepts", acc_cyc.size() - base, 3);
    if (acc_cyc.size() - base == 3) begin
      chk("b2b_gap1", acc_cyc[base + 1] - acc_cyc[base], 12);
      chk("b2b_gap2", acc_cyc[base + 2] - acc_cyc[base + 1], 12);
    end

    repeat (1500) begin
      @(posedge clk);
      #1;
      in_valid  = 1'($urandom_range(0, 1));
      in_count  = CW'($urandom);
      out_ready = $urandom_range(0, 2) != 0;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (B + 4) tick();
    chk("drain_idle", in_ready, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
